// File: rtl/alu_op_dispatcher_pkg.sv
// Shared parameters and types for the ALU issue stage: request payload and dispatcher states.
package alu_op_dispatcher_pkg;

  localparam int unsigned OPERAND_MAX_DATA_WIDTH = 16;
  localparam int unsigned OPCODE_WIDTH           = 3;
  localparam int unsigned FIFO_DEPTH             = 4;
  localparam int unsigned TIMEOUT_CYCLES         = 256;
  localparam int unsigned COUNT_WIDTH            = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]           opcode;
    logic [OPERAND_MAX_DATA_WIDTH-1:0] a;
    logic [OPERAND_MAX_DATA_WIDTH-1:0] b;
  } alu_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } dispatch_state_e;

endpackage

// File: rtl/alu_op_dispatcher_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB so full and empty differ only by wrap.
module alu_req_fifo
  import alu_op_dispatcher_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  alu_req_t                 wdata,
  input  logic                     pop,
  output alu_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  alu_req_t        mem_q [Depth];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop && !empty) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q[PtrW-1:0]];
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
            (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    count = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Queues ALU requests and issues them one at a time with a start pulse, holding until done.
// Optional WAIT watchdog enabled by defining ALU_DISPATCH_TIMEOUT_EN.
module alu_op_dispatcher
  import alu_op_dispatcher_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [OPCODE_WIDTH-1:0]           req_opcode,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_a,
  input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_b,
  output logic                              alu_start,
  output logic [OPCODE_WIDTH-1:0]           alu_opcode,
  output logic [OPERAND_MAX_DATA_WIDTH-1:0] alu_a,
  output logic [OPERAND_MAX_DATA_WIDTH-1:0] alu_b,
  input  logic                              alu_done,
  output logic [COUNT_WIDTH-1:0]            pending_count,
  output logic [15:0]                       issued_count,
  output logic                              err_timeout
);

  dispatch_state_e state_q, state_d;
  alu_req_t        fifo_rdata, wdata;
  alu_req_t        issue_q;
  logic            fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic            ready_en_q;
  logic [15:0]     issued_q;
  logic            timeout;

  // Ready comes from registers only, so it is low through reset and rises one cycle later.
  assign req_ready = ready_en_q && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign wdata     = '{opcode: req_opcode, a: req_a, b: req_b};

  alu_req_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_count)
  );

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne = 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            err_q;

  assign timeout     = (state_q == StWait) && !alu_done &&
                       (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + CntOne;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d  = StIssue;
          fifo_pop = 1'b1;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (alu_done) begin
          if (!fifo_empty) begin
            state_d  = StIssue;
            fifo_pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_start    = (state_q == StIssue);
    alu_opcode   = issue_q.opcode;
    alu_a        = issue_q.a;
    alu_b        = issue_q.b;
    issued_count = issued_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q    <= '0;
      issued_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (fifo_pop) begin
        issue_q <= fifo_rdata;
      end
      if (state_q == StIssue) begin
        issued_q <= issued_q + 16'd1;
      end
    end
  end

endmodule
